// File: rtl/data_mem_pkg.sv
// Shared constants for the data memory controller: state encoding, default
// data width and the cell-address field width of a sub-segment.
package data_mem_pkg;

    localparam int ADDR_W         = 16;
    localparam int CELL_ADDR_W    = 4;
    localparam int DATA_W_DEFAULT = 16;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_SETUP = 3'd1;
    localparam logic [2:0] S_WRITE = 3'd2;
    localparam logic [2:0] S_READ  = 3'd3;
    localparam logic [2:0] S_RESP  = 3'd4;

endpackage

// File: rtl/data_mem_ctrl_if.sv
// Processor-side and sub-segment-side bus of the data memory controller.
interface data_mem_ctrl_if #(
    parameter int NUM_SEG = 4,
    parameter int DATA_W  = 16
) ();

    logic                REQ_MC;
    logic                WR_MC;
    logic [15:0]         ADDR_MC;
    logic [DATA_W-1:0]   DATA_WR_MC;
    logic [DATA_W-1:0]   DATA_OUT_SS_MC;
    logic                ACK_MC;
    logic                ERR_MC;
    logic                BUSY_MC;
    logic [DATA_W-1:0]   DATA_RD_MC;
    logic [NUM_SEG-1:0]  SEG_SEL_MC;
    logic [3:0]          ADDR_SS_MC;
    logic [DATA_W-1:0]   DATA_IN_SS_MC;
    logic                WE_SS_MC;

    modport master (
        output REQ_MC, WR_MC, ADDR_MC, DATA_WR_MC, DATA_OUT_SS_MC,
        input  ACK_MC, ERR_MC, BUSY_MC, DATA_RD_MC, SEG_SEL_MC,
               ADDR_SS_MC, DATA_IN_SS_MC, WE_SS_MC
    );

    modport slave (
        input  REQ_MC, WR_MC, ADDR_MC, DATA_WR_MC, DATA_OUT_SS_MC,
        output ACK_MC, ERR_MC, BUSY_MC, DATA_RD_MC, SEG_SEL_MC,
               ADDR_SS_MC, DATA_IN_SS_MC, WE_SS_MC
    );

endinterface

// File: rtl/data_mem_ctrl_seg_select_decoder.sv
// Maps the segment field of a word address to a one-hot sub-segment select;
// any address beyond the last served segment yields all-zero and out-of-range.
module seg_select_decoder
    import data_mem_pkg::*;
#(
    parameter int NUM_SEG = 4
) (
    input  logic [ADDR_W-1:CELL_ADDR_W] seg_addr_i,
    output logic [NUM_SEG-1:0]          seg_sel_o,
    output logic                        in_range_o
);

    localparam int SEG_W = ADDR_W - CELL_ADDR_W;

    always_comb begin
        seg_sel_o = '0;
        for (int unsigned i = 0; i < NUM_SEG; i++) begin
            seg_sel_o[i] = (seg_addr_i == SEG_W'(i));
        end
        in_range_o = |seg_sel_o;
    end

endmodule

// File: rtl/data_mem_ctrl.sv
// Single-access data memory controller: latches a processor request, drives
// one sub-segment through SETUP/WRITE|READ and answers with a one-cycle ACK.
module data_mem_ctrl
    import data_mem_pkg::*;
#(
    parameter int NUM_SEG = 4,
    parameter int DATA_W  = DATA_W_DEFAULT
) (
    input  logic           CLK_MC,
    input  logic           RST_MC,
    data_mem_ctrl_if.slave bus
);

    logic [2:0]         state_q, state_d;
    logic               wr_q, wr_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic [DATA_W-1:0]  data_q, data_d;
    logic               in_range_q, in_range_d;
    logic [NUM_SEG-1:0] seg_sel_q, seg_sel_d;
    logic [DATA_W-1:0]  rd_q, rd_d;
    logic               ack_q, ack_d;
    logic               err_q, err_d;
    logic               busy_q, busy_d;
    logic               we_q, we_d;
    logic               accept;

    logic [NUM_SEG-1:0] dec_sel;
    logic               dec_in_range;

    // Decoding the next latched address lets the select be a plain register
    // that is already valid in SETUP.
    seg_select_decoder #(.NUM_SEG(NUM_SEG)) u_dec (
        .seg_addr_i (addr_d[ADDR_W-1:CELL_ADDR_W]),
        .seg_sel_o  (dec_sel),
        .in_range_o (dec_in_range)
    );

    assign accept = (state_q == S_IDLE) && bus.REQ_MC;

    always_comb begin
        state_d    = state_q;
        wr_d       = wr_q;
        addr_d     = addr_q;
        data_d     = data_q;
        rd_d       = rd_q;
        if (accept) begin
            wr_d   = bus.WR_MC;
            addr_d = bus.ADDR_MC;
            data_d = bus.DATA_WR_MC;
        end
        case (state_q)
            S_IDLE:  if (bus.REQ_MC) state_d = S_SETUP;
            S_SETUP: begin
                if (!in_range_q) begin
                    state_d = S_RESP;
                    rd_d    = '0;
                end else if (wr_q) begin
                    state_d = S_WRITE;
                end else begin
                    state_d = S_READ;
                end
            end
            S_WRITE: state_d = S_RESP;
            S_READ: begin
                state_d = S_RESP;
                rd_d    = bus.DATA_OUT_SS_MC;
            end
            S_RESP:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        seg_sel_d  = accept ? dec_sel : seg_sel_q;
        in_range_d = accept ? dec_in_range : in_range_q;
        busy_d     = (state_d != S_IDLE);
        ack_d      = (state_d == S_RESP);
        err_d      = ack_d && !in_range_q;
        we_d       = (state_d == S_WRITE);
    end

    always_ff @(posedge CLK_MC or posedge RST_MC) begin
        if (RST_MC) begin
            state_q    <= S_IDLE;
            wr_q       <= 1'b0;
            addr_q     <= '0;
            data_q     <= '0;
            in_range_q <= 1'b0;
            seg_sel_q  <= '0;
            rd_q       <= '0;
            ack_q      <= 1'b0;
            err_q      <= 1'b0;
            busy_q     <= 1'b0;
            we_q       <= 1'b0;
        end else begin
            state_q    <= state_d;
            wr_q       <= wr_d;
            addr_q     <= addr_d;
            data_q     <= data_d;
            in_range_q <= in_range_d;
            seg_sel_q  <= seg_sel_d;
            rd_q       <= rd_d;
            ack_q      <= ack_d;
            err_q      <= err_d;
            busy_q     <= busy_d;
            we_q       <= we_d;
        end
    end

    assign bus.ACK_MC        = ack_q;
    assign bus.ERR_MC        = err_q;
    assign bus.BUSY_MC       = busy_q;
    assign bus.DATA_RD_MC    = rd_q;
    assign bus.SEG_SEL_MC    = seg_sel_q;
    assign bus.ADDR_SS_MC    = addr_q[CELL_ADDR_W-1:0];
    assign bus.DATA_IN_SS_MC = data_q;
    assign bus.WE_SS_MC      = we_q;

endmodule
